// File: rtl/hold_timer_pkg.sv
// hold_timer_pkg: shared state encoding and default width for the hold timer array
package hold_timer_pkg;
   localparam int DEF_CNT_W = 8;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COUNT = 2'b01,
      ST_HELD  = 2'b10
   } state_t;
endpackage

// File: rtl/hold_timer_channel.sv
// hold_timer_channel: one hold-detect channel
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_in, i_en          synchronised level input, channel enable
//   i_limit, i_rpt_en   shared hold threshold (0 acts as 1), auto-repeat enable
//   o_f, o_pulse        HELD level, one-cycle entry/repeat strobe
module hold_timer_channel
   import hold_timer_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_in,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_limit,
   input  logic             i_rpt_en,
   output logic             o_f,
   output logic             o_pulse
);
   state_t           r_state, w_state_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx, r_lim, w_lim_nx, w_lim_eff, w_cnt_inc;
   logic             r_pulse, w_pulse_nx, w_one;

   assign w_lim_eff = (i_limit == '0) ? CNT_W'(1) : i_limit;
   assign w_one     = (w_lim_eff == CNT_W'(1));
   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign o_f       = (r_state == ST_HELD);
   assign o_pulse   = r_pulse;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_lim   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_lim   <= w_lim_nx;
         r_pulse <= w_pulse_nx;
      end
   end

   // A limit of one enters HELD directly with cnt=0, keeping cnt below lim_q
   // so the repeat comparison stays valid.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_lim_nx   = r_lim;
      w_pulse_nx = 1'b0;
      if (!i_en || !i_in) begin
         w_state_nx = ST_IDLE;
         w_cnt_nx   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_lim_nx   = w_lim_eff;
               w_pulse_nx = w_one;
               w_state_nx = w_one ? ST_HELD : ST_COUNT;
               w_cnt_nx   = w_one ? '0 : CNT_W'(1);
            end
            ST_COUNT: begin
               w_pulse_nx = (w_cnt_inc == r_lim);
               w_state_nx = w_pulse_nx ? ST_HELD : ST_COUNT;
               w_cnt_nx   = w_pulse_nx ? '0 : w_cnt_inc;
            end
            ST_HELD: begin
               w_pulse_nx = i_rpt_en && (w_cnt_inc == r_lim);
               w_cnt_nx   = (!i_rpt_en || w_pulse_nx) ? '0 : w_cnt_inc;
            end
            default: begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
            end
         endcase
      end
   end
endmodule

// File: rtl/hold_timer_array.sv
// hold_timer_array: multi-channel hold-detect timer
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_in, i_en          per-channel level input and enable
//   i_limit, i_rpt_en   shared hold threshold (0 acts as 1), auto-repeat enable
//   o_f, o_pulse        per-channel HELD level and entry/repeat strobe
//   o_any               OR of o_f
module hold_timer_array
   import hold_timer_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [CHANNELS-1:0] i_in,
   input  logic [CHANNELS-1:0] i_en,
   input  logic [CNT_W-1:0]    i_limit,
   input  logic                i_rpt_en,
   output logic [CHANNELS-1:0] o_f,
   output logic [CHANNELS-1:0] o_pulse,
   output logic                o_any
);
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      hold_timer_channel #(.CNT_W(CNT_W)) u_ch (
         .i_clk    (i_clk),
         .i_reset  (i_reset),
         .i_in     (i_in[g]),
         .i_en     (i_en[g]),
         .i_limit  (i_limit),
         .i_rpt_en (i_rpt_en),
         .o_f      (o_f[g]),
         .o_pulse  (o_pulse[g])
      );
   end

   assign o_any = |o_f;
endmodule

// File: tb/tb_hold_timer_array.sv
// tb_hold_timer_array: directed and random stimulus against a run-length reference model
module tb_hold_timer_array;
   logic       clk = 1'b0;
   logic       i_reset = 1'b1;
   logic [3:0] i_in = '0, i_en = '0;
   logic [7:0] i_limit = '0;
   logic       i_rpt_en = 1'b0;
   logic [3:0] o_f, o_pulse;
   logic       o_any;

   int vectors = 0, miscompares = 0;
   int run[4], lim_m[4], ph[4];
   logic [3:0] ef = '0, ep = '0;

   hold_timer_array dut (
      .i_clk(clk), .i_reset(i_reset), .i_in(i_in), .i_en(i_en), .i_limit(i_limit),
      .i_rpt_en(i_rpt_en), .o_f(o_f), .o_pulse(o_pulse), .o_any(o_any)
   );

   always #5 clk = ~clk;

   // run = consecutive enabled-high samples; HELD once run reaches the limit
   // captured at the first sample; ph counts repeat-enabled edges since the last strobe.
   task automatic model();
      for (int c = 0; c < 4; c++) begin
         ep[c] = 1'b0;
         if (i_reset || !(i_in[c] && i_en[c])) begin
            run[c] = 0;
            ph[c]  = 0;
         end else begin
            if (run[c] == 0) lim_m[c] = (i_limit == 0) ? 1 : int'(i_limit);
            run[c]++;
            if (run[c] == lim_m[c]) begin
               ep[c] = 1'b1;
               ph[c] = 0;
            end else if (run[c] > lim_m[c]) begin
               ph[c] = i_rpt_en ? ph[c] + 1 : 0;
               if (ph[c] == lim_m[c]) begin
                  ep[c] = 1'b1;
                  ph[c] = 0;
               end
            end
         end
         ef[c] = (run[c] > 0) && (run[c] >= lim_m[c]);
      end
   endtask

   task automatic check(input string tag);
      vectors++;
      assert (o_f === ef) else begin
         miscompares++;
         $error("FAIL %s f observed=%b expected=%b", tag, o_f, ef);
      end
      vectors++;
      assert (o_pulse === ep) else begin
         miscompares++;
         $error("FAIL %s pulse observed=%b expected=%b", tag, o_pulse, ep);
      end
      vectors++;
      assert (o_any === |ef) else begin
         miscompares++;
         $error("FAIL %s any observed=%b expected=%b", tag, o_any, |ef);
      end
   endtask

   task automatic step(input logic [3:0] in_v, input logic [3:0] en_v, input logic [7:0] lim_v,
                       input logic rpt_v, input logic rst_v, input string tag);
      i_in = in_v; i_en = en_v; i_limit = lim_v; i_rpt_en = rpt_v; i_reset = rst_v;
      @(posedge clk);
      model();
      #1 check(tag);
   endtask

   initial begin
      for (int c = 0; c < 4; c++) begin
         run[c] = 0; lim_m[c] = 0; ph[c] = 0;
      end
      for (int k = 0; k < 3; k++) step(4'hF, 4'hF, 8'd10, 1'b0, 1'b1, "reset");
      step(4'h0, 4'hF, 8'd10, 1'b0, 1'b0, "post_reset");
      for (int k = 0; k < 12; k++) step(4'h1, 4'hF, 8'd10, 1'b0, 1'b0, "hold10");
      step(4'h0, 4'hF, 8'd10, 1'b0, 1'b0, "release");
      for (int k = 0; k < 9; k++) step(4'h2, 4'hF, 8'd10, 1'b0, 1'b0, "short9");
      step(4'h0, 4'hF, 8'd10, 1'b0, 1'b0, "short_gap");
      for (int k = 0; k < 11; k++) step(4'h2, 4'hF, 8'd10, 1'b0, 1'b0, "repress");
      step(4'h0, 4'hF, 8'd0, 1'b0, 1'b0, "gap");
      for (int k = 0; k < 3; k++) step(4'h1, 4'hF, 8'd0, 1'b0, 1'b0, "limit0");
      step(4'h0, 4'hF, 8'd1, 1'b0, 1'b0, "gap");
      for (int k = 0; k < 3; k++) step(4'h1, 4'hF, 8'd1, 1'b0, 1'b0, "limit1");
      step(4'h0, 4'hF, 8'd255, 1'b0, 1'b0, "gap");
      for (int k = 0; k < 257; k++) step(4'h1, 4'hF, 8'd255, 1'b0, 1'b0, "limit255");
      step(4'h0, 4'hF, 8'd4, 1'b1, 1'b0, "gap");
      for (int k = 0; k < 16; k++) step(4'h4, 4'hF, 8'd4, 1'b1, 1'b0, "repeat4");
      for (int k = 0; k < 6; k++) step(4'h4, 4'hF, 8'd4, 1'b0, 1'b0, "rpt_off_mid");
      step(4'h0, 4'hF, 8'd4, 1'b0, 1'b0, "gap");
      for (int k = 0; k < 16; k++) step(4'h4, 4'hF, 8'd4, 1'b0, 1'b0, "norepeat");
      step(4'h0, 4'hF, 8'd10, 1'b0, 1'b0, "gap");
      for (int k = 0; k < 5; k++) step(4'h8, 4'hF, 8'd10, 1'b0, 1'b0, "lim_change_a");
      for (int k = 0; k < 7; k++) step(4'h8, 4'hF, 8'd3, 1'b0, 1'b0, "lim_change_b");
      step(4'h8, 4'h7, 8'd3, 1'b0, 1'b0, "en_drop");
      step(4'h0, 4'h7, 8'd3, 1'b0, 1'b0, "in_en_low");
      for (int k = 0; k < 4; k++) step(4'hF, 4'hF, 8'd3, 1'b1, 1'b0, "all_hold");
      step(4'hF, 4'hF, 8'd3, 1'b1, 1'b1, "reset_held");
      step(4'hF, 4'hF, 8'd3, 1'b1, 1'b0, "after_reset");
      for (int k = 0; k < 3000; k++) begin
         logic [3:0] r_in, r_en;
         logic [7:0] r_lim;
         r_in  = 4'($urandom) | 4'($urandom) | 4'($urandom);
         r_en  = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
         r_lim = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
         step(r_in, r_en, r_lim, 1'($urandom), $urandom_range(0, 199) == 0, "random");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
